dmem_arbiter: RTL and testbench

//   Shares one byte-addressed data memory (async read, negedge write) between two requesters:
//   m0 = CPU load/store port, m1 = loader/DMA port. Round-robin grant, valid/ready request

---
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_arbiter.sv | 134 +++++++++++++
 tb/tb_dmem_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters (m0 CPU, m1 loader/DMA)
// and the data memory. The slave modport is the arbiter's view; master is the environment's.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              m0_req_valid;
   logic              m0_req_ready;
   logic              m0_req_we;
   logic [ADDR_W-1:0] m0_req_addr;
   logic [DATA_W-1:0] m0_req_wdata;
   logic              m0_rsp_valid;
   logic [DATA_W-1:0] m0_rsp_rdata;
   logic              m0_rsp_err;

   logic              m1_req_valid;
   logic              m1_req_ready;
   logic              m1_req_we;
   logic [ADDR_W-1:0] m1_req_addr;
   logic [DATA_W-1:0] m1_req_wdata;
   logic              m1_rsp_valid;
   logic [DATA_W-1:0] m1_rsp_rdata;
   logic              m1_rsp_err;

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  m0_req_valid, m0_req_we, m0_req_addr, m0_req_wdata,
      output m0_req_ready, m0_rsp_valid, m0_rsp_rdata, m0_rsp_err,
      input  m1_req_valid, m1_req_we, m1_req_addr, m1_req_wdata,
      output m1_req_ready, m1_rsp_valid, m1_rsp_rdata, m1_rsp_err,
      output mem_read, mem_write, mem_addr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output m0_req_valid, m0_req_we, m0_req_addr, m0_req_wdata,
      input  m0_req_ready, m0_rsp_valid, m0_rsp_rdata, m0_rsp_err,
      output m1_req_valid, m1_req_we, m1_req_addr, m1_req_wdata,
      input  m1_req_ready, m1_rsp_valid, m1_rsp_rdata, m1_rsp_err,
      input  mem_read, mem_write, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between m0 (CPU) and m1 (loader/DMA).
// Optional ALIGN_CHECK_EN: misaligned / out-of-range requests are answered with rsp_err.
//
// state  | meaning
// IDLE   | waiting for a request; ready offered to the arbitration winner
// ACCESS | latched request driven onto the memory; read data captured at closing edge
// RESP   | one-cycle response pulse to the requester that was granted
module dmem_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_BYTES = 1024
) (
   input  logic           clk,
   input  logic           reset,
   dmem_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              id_q, id_d;
   logic              we_q, we_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic              winner;
   logic              hs;
   logic              win_we;
   logic              win_err;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;
   logic              in_access;
   logic              in_resp;

   // On a tie the port that did not win last time goes first; otherwise the lone requester.
   always_comb begin
      if (bus.m0_req_valid && bus.m1_req_valid) begin
         winner = ~last_grant_q;
      end else begin
         winner = bus.m1_req_valid;
      end
      win_we    = winner ? bus.m1_req_we    : bus.m0_req_we;
      win_addr  = winner ? bus.m1_req_addr  : bus.m0_req_addr;
      win_wdata = winner ? bus.m1_req_wdata : bus.m0_req_wdata;
      hs        = (state_q == S_IDLE) && reset && (bus.m0_req_valid || bus.m1_req_valid);
   end

`ifdef ALIGN_CHECK_EN
   assign win_err = (win_addr[1:0] != 2'b00) || (win_addr > ADDR_W'(MEM_BYTES - 4));
`else
   assign win_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         we_q         <= 1'b0;
         err_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         id_q         <= id_d;
         we_q         <= we_d;
         err_q        <= err_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      id_d         = id_q;
      we_d         = we_q;
      err_d        = err_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      unique case (state_q)
         S_IDLE: begin
            if (hs) begin
               last_grant_d = winner;
               id_d         = winner;
               we_d         = win_we;
               err_d        = win_err;
               addr_d       = win_addr;
               wdata_d      = win_wdata;
               state_d      = S_ACCESS;
            end
         end
         S_ACCESS: begin
            rdata_d = (we_q || err_q) ? '0 : bus.mem_rdata;
            state_d = S_RESP;
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Memory strobes decode straight from state so an async reset drops them immediately.
   assign in_access     = (state_q == S_ACCESS);
   assign in_resp       = (state_q == S_RESP);

   assign bus.mem_read  = in_access && !we_q && !err_q;
   assign bus.mem_write = in_access &&  we_q && !err_q;
   assign bus.mem_addr  = in_access ? addr_q  : '0;
   assign bus.mem_wdata = in_access ? wdata_q : '0;

   assign bus.m0_req_ready = hs && !winner;
   assign bus.m1_req_ready = hs &&  winner;

   assign bus.m0_rsp_valid = in_resp && !id_q;
   assign bus.m1_rsp_valid = in_resp &&  id_q;
   assign bus.m0_rsp_rdata = (in_resp && !id_q) ? rdata_q : '0;
   assign bus.m1_rsp_rdata = (in_resp &&  id_q) ? rdata_q : '0;
   assign bus.m0_rsp_err   = in_resp && !id_q && err_q;
   assign bus.m1_rsp_err   = in_resp &&  id_q && err_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: 256-word memory model, timeline-based reference checked every
// cycle, plus directed scenarios with literal expectations.
module tb_dmem_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

`ifdef ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(1024)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // 256-word memory: async read, negedge write, physically wraps every 1 KiB
   logic [31:0] tb_mem [256];
   bit mem_init_done = 1'b0;
   assign bus.mem_rdata = tb_mem[bus.mem_addr[9:2]];
   always @(negedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 256; i++) tb_mem[i] <= 32'hA500_0000 | 32'(i);
         mem_init_done <= 1'b1;
      end else if (bus.mem_write) begin
         tb_mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      end
   end

   // Reference: a transaction accepted in cycle c occupies the memory in c+1, answers in c+2,
   // and the arbiter is free again from c+3.
   logic [31:0] ref_mem [int];
   function automatic logic [31:0] model_rd(input logic [31:0] a);
      int k;
      k = int'(a[9:2]);
      return ref_mem.exists(k) ? ref_mem[k] : (32'hA500_0000 | 32'(k));
   endfunction

   int cyc = 0;
   int acc_cyc = -10;
   int rsp_cyc = -10;
   bit lg = 1'b1;
   bit t_id, t_we, t_err;
   logic [31:0] t_addr, t_wdata, t_rdata;
   int hs_port_q[$];
   int hs_cyc_q[$];
   int wr_count = 0;
   int rsp_cnt0 = 0, rsp_cnt1 = 0;
   logic [31:0] last_rdata0 = '0, last_rdata1 = '0;
   logic last_err0 = 1'b0;

   always @(negedge clk) begin
      bit idle, win, e_r0, e_r1, acc, rsp, r0, r1;
      logic [31:0] e_rd;
      cyc++;
      if (!reset) begin
         chk("reset_strobes", {bus.m0_req_ready, bus.m1_req_ready, bus.m0_rsp_valid,
             bus.m1_rsp_valid, bus.m0_rsp_err, bus.m1_rsp_err, bus.mem_read, bus.mem_write}, 0);
         chk("reset_buses", bus.mem_addr | bus.mem_wdata | bus.m0_rsp_rdata | bus.m1_rsp_rdata, 0);
         acc_cyc = -10;
         rsp_cyc = -10;
         lg = 1'b1;
      end else begin
         idle = (cyc > rsp_cyc);
         if (bus.m0_req_valid && bus.m1_req_valid) win = (lg == 1'b1) ? 1'b0 : 1'b1;
         else if (bus.m1_req_valid) win = 1'b1;
         else win = 1'b0;
         e_r0 = idle && bus.m0_req_valid && (win == 1'b0);
         e_r1 = idle && bus.m1_req_valid && (win == 1'b1);
         acc = (cyc == acc_cyc);
         rsp = (cyc == rsp_cyc);
         if (acc && !t_err) begin
            if (t_we) ref_mem[int'(t_addr[9:2])] = t_wdata;
            else t_rdata = model_rd(t_addr);
         end
         r0 = rsp && !t_id;
         r1 = rsp && t_id;
         e_rd = (t_we || t_err) ? 32'h0 : t_rdata;
         chk("m0_req_ready", bus.m0_req_ready, e_r0);
         chk("m1_req_ready", bus.m1_req_ready, e_r1);
         chk("mem_read",  bus.mem_read,  acc && !t_we && !t_err);
         chk("mem_write", bus.mem_write, acc &&  t_we && !t_err);
         chk("mem_addr",  bus.mem_addr,  acc ? t_addr  : 32'h0);
         chk("mem_wdata", bus.mem_wdata, acc ? t_wdata : 32'h0);
         chk("m0_rsp_valid", bus.m0_rsp_valid, r0);
         chk("m1_rsp_valid", bus.m1_rsp_valid, r1);
         chk("m0_rsp_rdata", bus.m0_rsp_rdata, r0 ? e_rd : 32'h0);
         chk("m1_rsp_rdata", bus.m1_rsp_rdata, r1 ? e_rd : 32'h0);
         chk("m0_rsp_err", bus.m0_rsp_err, r0 && t_err);
         chk("m1_rsp_err", bus.m1_rsp_err, r1 && t_err);
         if (bus.mem_write) wr_count++;
         if (bus.m0_rsp_valid) begin
            rsp_cnt0++;
            last_rdata0 = bus.m0_rsp_rdata;
            last_err0 = bus.m0_rsp_err;
         end
         if (bus.m1_rsp_valid) begin
            rsp_cnt1++;
            last_rdata1 = bus.m1_rsp_rdata;
         end
         if (e_r0 || e_r1) begin
            t_id    = win;
            t_we    = win ? bus.m1_req_we    : bus.m0_req_we;
            t_addr  = win ? bus.m1_req_addr  : bus.m0_req_addr;
            t_wdata = win ? bus.m1_req_wdata : bus.m0_req_wdata;
            t_err   = ALIGN && ((t_addr % 4) != 0 || t_addr > 32'd1020);
            acc_cyc = cyc + 1;
            rsp_cyc = cyc + 2;
            lg = win;
            hs_port_q.push_back(int'(win));
            hs_cyc_q.push_back(cyc);
         end
      end
   end

   task automatic do_req(input bit port, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, output int waited);
      bit got;
      @(posedge clk); #1;
      if (!port) begin
         bus.m0_req_we = we; bus.m0_req_addr = addr; bus.m0_req_wdata = wdata; bus.m0_req_valid = 1'b1;
      end else begin
         bus.m1_req_we = we; bus.m1_req_addr = addr; bus.m1_req_wdata = wdata; bus.m1_req_valid = 1'b1;
      end
      waited = 0;
      got = 1'b0;
      while (!got && waited <= 30) begin
         @(negedge clk);
         if (port ? bus.m1_req_ready : bus.m0_req_ready) got = 1'b1;
         else waited++;
      end
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL req_timeout: port %0d got no ready, expected ready within 30 cycles", port);
      end
      @(posedge clk); #1;
      bus.m0_req_valid = 1'b0;
      bus.m1_req_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      repeat (2) @(negedge clk);
      #1;
   endtask

   initial begin
      int w, b, c0, c1, wr0;
      bus.m0_req_valid = 1'b0; bus.m0_req_we = 1'b0; bus.m0_req_addr = '0; bus.m0_req_wdata = '0;
      bus.m1_req_valid = 1'b0; bus.m1_req_we = 1'b0; bus.m1_req_addr = '0; bus.m1_req_wdata = '0;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk); #1;
      chk("post_reset_idle", {bus.m0_req_ready, bus.m0_rsp_valid, bus.mem_write, bus.mem_read}, 0);

      // store then load on m0
      c1 = rsp_cnt1;
      do_req(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, w);
      wait_rsp();
      chk("t1_store_rsp_rdata", last_rdata0, 32'h0);
      do_req(1'b0, 1'b0, 32'h10, 32'h0, w);
      wait_rsp();
      chk("t1_load_rdata", last_rdata0, 32'hDEAD_BEEF);
      chk("t1_no_m1_rsp", rsp_cnt1 - c1, 0);

      // both requesters held valid from reset
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      bus.m0_req_we = 1'b0; bus.m0_req_addr = 32'h10; bus.m0_req_valid = 1'b1;
      bus.m1_req_we = 1'b0; bus.m1_req_addr = 32'h14; bus.m1_req_valid = 1'b1;
      b = hs_port_q.size();
      reset = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      bus.m0_req_valid = 1'b0;
      bus.m1_req_valid = 1'b0;
      chk("t2_grant_count", hs_port_q.size() - b, 4);
      if (hs_port_q.size() >= b + 4) begin
         chk("t2_grant0", hs_port_q[b],     0);
         chk("t2_grant1", hs_port_q[b + 1], 1);
         chk("t2_grant2", hs_port_q[b + 2], 0);
         chk("t2_grant3", hs_port_q[b + 3], 1);
         chk("t2_gap", hs_cyc_q[b + 1] - hs_cyc_q[b], 3);
      end
      repeat (3) @(posedge clk);

      // m1 back-to-back stores
      wr0 = wr_count;
      b = hs_port_q.size();
      do_req(1'b1, 1'b1, 32'h0, 32'h11, w);
      do_req(1'b1, 1'b1, 32'h4, 32'h22, w);
      do_req(1'b1, 1'b1, 32'h8, 32'h33, w);
      wait_rsp();
      chk("t3_write_cycles", wr_count - wr0, 3);
      chk("t3_hs_count", hs_port_q.size() - b, 3);
      if (hs_port_q.size() >= b + 3) begin
         chk("t3_gap01", hs_cyc_q[b + 1] - hs_cyc_q[b], 3);
         chk("t3_gap12", hs_cyc_q[b + 2] - hs_cyc_q[b + 1], 3);
         chk("t3_port", hs_port_q[b + 2], 1);
      end
      chk("t3_last_rdata", last_rdata1, 32'h0);

      // reset in the middle of a store's ACCESS cycle
      c0 = rsp_cnt0;
      c1 = rsp_cnt1;
      do_req(1'b0, 1'b1, 32'h20, 32'h1234_5678, w);
      #1;
      chk("t4_mem_write_before", bus.mem_write, 1'b1);
      reset = 1'b0;
      #1;
      chk("t4_mem_write_after", bus.mem_write, 1'b0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("t4_mem_unchanged", tb_mem[8], 32'hA500_0008);
      chk("t4_no_rsp", (rsp_cnt0 - c0) + (rsp_cnt1 - c1), 0);
      do_req(1'b0, 1'b0, 32'h20, 32'h0, w);
      chk("t4_idle_after_reset", w, 0);
      wait_rsp();
      chk("t4_load_rdata", last_rdata0, 32'hA500_0008);

      // alignment / range requests
      c1 = rsp_cnt1;
      c0 = rsp_cnt0;
      do_req(1'b0, 1'b0, 32'h13, 32'h0, w);
      wait_rsp();
      chk("t5_err_13", last_err0, ALIGN);
      chk("t5_rdata_13", last_rdata0, ALIGN ? 32'h0 : 32'hDEAD_BEEF);
      do_req(1'b0, 1'b0, 32'h400, 32'h0, w);
      wait_rsp();
      chk("t5_err_400", last_err0, ALIGN);
      chk("t5_rdata_400", last_rdata0, ALIGN ? 32'h0 : 32'h11);
      do_req(1'b0, 1'b0, 32'h3FC, 32'h0, w);
      wait_rsp();
      chk("t5_err_3fc", last_err0, 1'b0);
      chk("t5_rdata_3fc", last_rdata0, 32'hA500_00FF);
      chk("t5_rsp_count", rsp_cnt0 - c0, 3);
      chk("t6_no_m1_rsp", rsp_cnt1 - c1, 0);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
      $fatal(1, "timeout");
   end
endmodule
